// File: rtl/debug_loader_if.sv
// rtl/debug_loader_if.sv - UART byte stream, response stream and instruction-memory write bus of debug_loader
// Parameters: SIZE (instruction word width), MAX_INSTRUCTION (instruction memory depth in words)
// Signals:
//   i_rx_data/i_rx_valid   received byte and its one-cycle strobe
//   o_tx_data/o_tx_valid   response byte, held until i_tx_ready accepts it
//   o_stall                processor pipeline freeze
//   o_inst_we/o_inst_addr/o_inst_data  one-cycle instruction-memory write
// Modports: master = debug_loader side, slave = UART / processor side
interface debug_loader_if #(
    parameter int SIZE            = 32,
    parameter int MAX_INSTRUCTION = 10
) ();
    localparam int ADDR_W = $clog2(MAX_INSTRUCTION);

    logic [7:0]        i_rx_data;
    logic              i_rx_valid;
    logic [7:0]        o_tx_data;
    logic              o_tx_valid;
    logic              i_tx_ready;
    logic              o_stall;
    logic              o_inst_we;
    logic [ADDR_W-1:0] o_inst_addr;
    logic [SIZE-1:0]   o_inst_data;

    modport master (
        input  i_rx_data, i_rx_valid, i_tx_ready,
        output o_tx_data, o_tx_valid, o_stall, o_inst_we, o_inst_addr, o_inst_data
    );

    modport slave (
        output i_rx_data, i_rx_valid, i_tx_ready,
        input  o_tx_data, o_tx_valid, o_stall, o_inst_we, o_inst_addr, o_inst_data
    );
endinterface

// File: rtl/debug_loader.sv
// rtl/debug_loader.sv - UART-driven debug controller: halt/run the core and load instruction memory
// Parameters: SIZE (instruction word width), MAX_INSTRUCTION (memory depth in words)
// Ports:
//   clk   single clock, rising edge
//   rst   asynchronous active-low reset
//   bus   debug_loader_if.master: rx byte stream, tx response, o_stall, instruction write bus
// Commands (byte in IDLE): 'L' N <4*N bytes LE> load, 'R' run, 'H' halt; ACK 0x06 / NAK 0x15.
// Optional macro DEBUG_STEP_EN: 'S' while halted releases the stall for exactly one cycle.
module debug_loader #(
    parameter int SIZE            = 32,
    parameter int MAX_INSTRUCTION = 10
) (
    input  logic           clk,
    input  logic           rst,
    debug_loader_if.master bus
);
    localparam int         ADDR_W = $clog2(MAX_INSTRUCTION);
    localparam logic [7:0] MAX_N  = 8'(MAX_INSTRUCTION);
    localparam logic [7:0] ACK    = 8'h06;
    localparam logic [7:0] NAK    = 8'h15;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_CNT,
        LOAD_DATA,
        WRITE,
`ifdef DEBUG_STEP_EN
        STEP,
`endif
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic              stall_q, stall_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              inst_we_q, inst_we_d;
    logic [ADDR_W-1:0] inst_addr_q, inst_addr_d;
    logic [SIZE-1:0]   inst_data_q, inst_data_d;
    logic [7:0]        word_cnt_q, word_cnt_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [7:0]        n_words_q, n_words_d;
    logic [23:0]       asm_q, asm_d;      // low three bytes of the word being assembled

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            stall_q     <= 1'b1;
            tx_data_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
            inst_we_q   <= 1'b0;
            inst_addr_q <= '0;
            inst_data_q <= '0;
            word_cnt_q  <= 8'h00;
            byte_cnt_q  <= 2'd0;
            n_words_q   <= 8'h00;
            asm_q       <= 24'h0;
        end else begin
            state_q     <= state_d;
            stall_q     <= stall_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            inst_we_q   <= inst_we_d;
            inst_addr_q <= inst_addr_d;
            inst_data_q <= inst_data_d;
            word_cnt_q  <= word_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            n_words_q   <= n_words_d;
            asm_q       <= asm_d;
        end
    end

    // Every output is registered, so a command byte takes effect on the edge that samples it.
    always_comb begin
        state_d     = state_q;
        stall_d     = stall_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        inst_we_d   = 1'b0;
        inst_addr_d = inst_addr_q;
        inst_data_d = inst_data_q;
        word_cnt_d  = word_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        n_words_d   = n_words_q;
        asm_d       = asm_q;

        case (state_q)
            IDLE: begin
                if (bus.i_rx_valid) begin
                    state_d    = RESP;
                    tx_valid_d = 1'b1;
                    tx_data_d  = NAK;
                    case (bus.i_rx_data)
                        8'h4C: begin
                            // loading is only allowed while the core is frozen
                            if (stall_q) begin
                                state_d    = LOAD_CNT;
                                tx_valid_d = 1'b0;
                                tx_data_d  = tx_data_q;
                            end
                        end
                        8'h52: begin
                            stall_d   = 1'b0;
                            tx_data_d = ACK;
                        end
                        8'h48: begin
                            stall_d   = 1'b1;
                            tx_data_d = ACK;
                        end
`ifdef DEBUG_STEP_EN
                        8'h53: begin
                            if (stall_q) begin
                                state_d    = STEP;
                                stall_d    = 1'b0;
                                tx_valid_d = 1'b0;
                                tx_data_d  = tx_data_q;
                            end
                        end
`endif
                        default: ;
                    endcase
                end
            end

            LOAD_CNT: begin
                if (bus.i_rx_valid) begin
                    if (bus.i_rx_data != 8'h00 && bus.i_rx_data <= MAX_N) begin
                        state_d    = LOAD_DATA;
                        n_words_d  = bus.i_rx_data;
                        word_cnt_d = 8'h00;
                        byte_cnt_d = 2'd0;
                    end else begin
                        state_d    = RESP;
                        tx_valid_d = 1'b1;
                        tx_data_d  = NAK;
                    end
                end
            end

            LOAD_DATA: begin
                if (bus.i_rx_valid) begin
                    if (byte_cnt_q == 2'd3) begin
                        state_d     = WRITE;
                        inst_we_d   = 1'b1;
                        inst_addr_d = word_cnt_q[ADDR_W-1:0];
                        inst_data_d = SIZE'({bus.i_rx_data, asm_q});
                        byte_cnt_d  = 2'd0;
                    end else begin
                        asm_d[byte_cnt_q*8 +: 8] = bus.i_rx_data;
                        byte_cnt_d               = byte_cnt_q + 2'd1;
                    end
                end
            end

            WRITE: begin
                word_cnt_d = word_cnt_q + 8'd1;
                if (word_cnt_q + 8'd1 == n_words_q) begin
                    state_d    = RESP;
                    tx_valid_d = 1'b1;
                    tx_data_d  = ACK;
                end else begin
                    state_d = LOAD_DATA;
                    // the host may stream the next word back-to-back
                    if (bus.i_rx_valid) begin
                        asm_d[7:0] = bus.i_rx_data;
                        byte_cnt_d = 2'd1;
                    end
                end
            end

`ifdef DEBUG_STEP_EN
            STEP: begin
                stall_d    = 1'b1;
                state_d    = RESP;
                tx_valid_d = 1'b1;
                tx_data_d  = ACK;
            end
`endif

            RESP: begin
                if (bus.i_tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.o_stall     = stall_q;
    assign bus.o_tx_data   = tx_data_q;
    assign bus.o_tx_valid  = tx_valid_q;
    assign bus.o_inst_we   = inst_we_q;
    assign bus.o_inst_addr = inst_addr_q;
    assign bus.o_inst_data = inst_data_q;
endmodule

// File: tb/tb_debug_loader.sv
// tb/tb_debug_loader.sv - cycle-by-cycle vector bench for debug_loader (default build or DEBUG_STEP_EN)
module tb_debug_loader;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tot = 0;
    int   bad = 0;

    debug_loader_if #(.SIZE(32), .MAX_INSTRUCTION(10)) bus ();

    debug_loader #(.SIZE(32), .MAX_INSTRUCTION(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        r;
        logic        st;
        logic        we;
        logic [3:0]  ad;
        logic [31:0] dat;
        logic        tv;
        logic [7:0]  td;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic v, input logic [7:0] d, input logic r, input logic st,
                       input logic we, input logic [3:0] ad, input logic [31:0] dat,
                       input logic tv, input logic [7:0] td);
        vec_t x;
        x.v = v; x.d = d; x.r = r; x.st = st; x.we = we;
        x.ad = ad; x.dat = dat; x.tv = tv; x.td = td;
        tbl.push_back(x);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
        tot++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s (step %0d): got %0h want %0h", name, idx, got, want);
        end
    endtask

    // Drive inputs for one cycle (starting at a negedge), then check outputs at the next negedge.
    task automatic apply(input vec_t x, input int idx);
        bus.i_rx_valid = x.v;
        bus.i_rx_data  = x.d;
        bus.i_tx_ready = x.r;
        @(negedge clk);
        bus.i_rx_valid = 1'b0;
        chk("stall", idx, 32'(bus.o_stall), 32'(x.st));
        chk("inst_we", idx, 32'(bus.o_inst_we), 32'(x.we));
        if (x.we) begin
            chk("inst_addr", idx, 32'(bus.o_inst_addr), 32'(x.ad));
            chk("inst_data", idx, bus.o_inst_data, x.dat);
        end
        chk("tx_valid", idx, 32'(bus.o_tx_valid), 32'(x.tv));
        if (x.tv) chk("tx_data", idx, 32'(bus.o_tx_data), 32'(x.td));
    endtask

    task automatic run(input logic v, input logic [7:0] d, input logic r, input logic st,
                       input logic we, input logic [3:0] ad, input logic [31:0] dat,
                       input logic tv, input logic [7:0] td, input int idx);
        vec_t x;
        x.v = v; x.d = d; x.r = r; x.st = st; x.we = we;
        x.ad = ad; x.dat = dat; x.tv = tv; x.td = td;
        apply(x, idx);
    endtask

    initial begin
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = 8'h00;
        bus.i_tx_ready = 1'b1;

        // two-word load, second word streamed during the WRITE cycle
        add(1, 8'h4C, 1, 1, 0, 0, 0, 0, 0);
        add(1, 8'h02, 1, 1, 0, 0, 0, 0, 0);
        add(1, 8'h78, 1, 1, 0, 0, 0, 0, 0);
        add(1, 8'h56, 1, 1, 0, 0, 0, 0, 0);
        add(1, 8'h34, 1, 1, 0, 0, 0, 0, 0);
        add(1, 8'h12, 1, 1, 1, 0, 32'h12345678, 0, 0);
        add(1, 8'hEF, 1, 1, 0, 0, 0, 0, 0);
        add(1, 8'hBE, 1, 1, 0, 0, 0, 0, 0);
        add(1, 8'hAD, 1, 1, 0, 0, 0, 0, 0);
        add(1, 8'hDE, 1, 1, 1, 1, 32'hDEADBEEF, 0, 0);
        add(0, 8'h00, 1, 1, 0, 0, 0, 1, 8'h06);
        add(0, 8'h00, 1, 1, 0, 0, 0, 0, 0);
        // N = 0 and N = MAX+1 rejected
        add(1, 8'h4C, 1, 1, 0, 0, 0, 0, 0);
        add(1, 8'h00, 1, 1, 0, 0, 0, 1, 8'h15);
        add(0, 8'h00, 1, 1, 0, 0, 0, 0, 0);
        add(1, 8'h4C, 1, 1, 0, 0, 0, 0, 0);
        add(1, 8'h0B, 1, 1, 0, 0, 0, 1, 8'h15);
        add(0, 8'h00, 1, 1, 0, 0, 0, 0, 0);
        // run, then 'L', unknown byte and 'S' while running are refused
        add(1, 8'h52, 1, 0, 0, 0, 0, 1, 8'h06);
        add(0, 8'h00, 1, 0, 0, 0, 0, 0, 0);
        add(1, 8'h4C, 1, 0, 0, 0, 0, 1, 8'h15);
        add(0, 8'h00, 1, 0, 0, 0, 0, 0, 0);
        add(1, 8'h41, 1, 0, 0, 0, 0, 1, 8'h15);
        add(0, 8'h00, 1, 0, 0, 0, 0, 0, 0);
        add(1, 8'h53, 1, 0, 0, 0, 0, 1, 8'h15);
        add(0, 8'h00, 1, 0, 0, 0, 0, 0, 0);
        // halt; a byte arriving while the response waits is dropped
        add(1, 8'h48, 0, 1, 0, 0, 0, 1, 8'h06);
        add(1, 8'h52, 0, 1, 0, 0, 0, 1, 8'h06);
        add(0, 8'h00, 1, 1, 0, 0, 0, 0, 0);
        add(0, 8'h00, 1, 1, 0, 0, 0, 0, 0);
`ifdef DEBUG_STEP_EN
        // single step: stall low for one cycle, then ACK held against backpressure
        add(1, 8'h53, 0, 0, 0, 0, 0, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0, 0, 1, 8'h06);
        for (int i = 0; i < 5; i++) add(0, 8'h00, 0, 1, 0, 0, 0, 1, 8'h06);
`else
        // 'S' is unknown: NAK held against backpressure
        add(1, 8'h53, 0, 1, 0, 0, 0, 1, 8'h15);
        for (int i = 0; i < 5; i++) add(0, 8'h00, 0, 1, 0, 0, 0, 1, 8'h15);
`endif
        add(0, 8'h00, 1, 1, 0, 0, 0, 0, 0);

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_stall", 0, 32'(bus.o_stall), 32'd1);
        chk("rst_we", 0, 32'(bus.o_inst_we), 32'd0);
        chk("rst_tx_valid", 0, 32'(bus.o_tx_valid), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_stall", 0, 32'(bus.o_stall), 32'd1);
        chk("idle_tx_valid", 0, 32'(bus.o_tx_valid), 32'd0);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // reset mid-load aborts; a fresh load starts clean
        run(1, 8'h4C, 1, 1, 0, 0, 0, 0, 0, 100);
        run(1, 8'h01, 1, 1, 0, 0, 0, 0, 0, 101);
        run(1, 8'hAA, 1, 1, 0, 0, 0, 0, 0, 102);
        run(1, 8'hBB, 1, 1, 0, 0, 0, 0, 0, 103);
        rst = 1'b0;
        #1;
        chk("abort_stall", 104, 32'(bus.o_stall), 32'd1);
        chk("abort_we", 104, 32'(bus.o_inst_we), 32'd0);
        chk("abort_tx_valid", 104, 32'(bus.o_tx_valid), 32'd0);
        chk("abort_addr", 104, 32'(bus.o_inst_addr), 32'd0);
        chk("abort_data", 104, bus.o_inst_data, 32'd0);
        chk("abort_tx_data", 104, 32'(bus.o_tx_data), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run(0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 105);
        run(1, 8'h4C, 1, 1, 0, 0, 0, 0, 0, 106);
        run(1, 8'h01, 1, 1, 0, 0, 0, 0, 0, 107);
        run(1, 8'h11, 1, 1, 0, 0, 0, 0, 0, 108);
        run(1, 8'h22, 1, 1, 0, 0, 0, 0, 0, 109);
        run(1, 8'h33, 1, 1, 0, 0, 0, 0, 0, 110);
        run(1, 8'h44, 1, 1, 1, 0, 32'h44332211, 0, 0, 111);
        run(0, 8'h00, 1, 1, 0, 0, 0, 1, 8'h06, 112);
        run(0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 113);

        // full-depth load, N = MAX_INSTRUCTION, bytes streamed every cycle
        run(1, 8'h4C, 1, 1, 0, 0, 0, 0, 0, 200);
        run(1, 8'h0A, 1, 1, 0, 0, 0, 0, 0, 201);
        for (int w = 0; w < 10; w++) begin
            logic [7:0] b0;
            b0 = 8'(4 * w + 16);
            run(1, b0,        1, 1, 0, 0, 0, 0, 0, 210 + w);
            run(1, b0 + 8'd1, 1, 1, 0, 0, 0, 0, 0, 210 + w);
            run(1, b0 + 8'd2, 1, 1, 0, 0, 0, 0, 0, 210 + w);
            run(1, b0 + 8'd3, 1, 1, 1, 4'(w),
                {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0}, 0, 0, 210 + w);
        end
        run(0, 8'h00, 1, 1, 0, 0, 0, 1, 8'h06, 230);
        run(0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 231);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule

// File: doc/debug_loader.md
DEBUG_LOADER -- requirements
Module: debug_loader

Interface
REQ-001 Parameter SIZE, default 32, instruction word width in bits.
REQ-002 Parameter MAX_INSTRUCTION, default 10, instruction-memory depth in words; ADDR_W = $clog2(MAX_INSTRUCTION).
REQ-003 clk  input  1  single clock; all state on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 i_rx_data  input  8  received byte from the UART receiver.
REQ-006 i_rx_valid  input  1  one-cycle strobe; i_rx_data is valid in that cycle.
REQ-007 o_tx_data  output  8  response byte to the UART transmitter.
REQ-008 o_tx_valid  output  1  response pending; held until accepted.
REQ-009 i_tx_ready  input  1  transmitter accepts o_tx_data on a rising edge where o_tx_valid and i_tx_ready are both 1.
REQ-010 o_stall  output  1  drives the processor i_stall; 1 freezes all pipeline latches.
REQ-011 o_inst_we  output  1  one-cycle instruction-memory write strobe.
REQ-012 o_inst_addr  output  ADDR_W  word address for o_inst_we.
REQ-013 o_inst_data  output  SIZE  instruction word for o_inst_we.

Function
REQ-014 FSM states: IDLE, LOAD_CNT, LOAD_DATA, WRITE, STEP, RESP.
REQ-015 In IDLE, a strobed byte is decoded: 0x4C 'L' -> LOAD_CNT; 0x52 'R' -> o_stall=0, RESP(ACK); 0x48 'H' -> o_stall=1, RESP(ACK); any other byte -> RESP(NAK).
REQ-016 ACK byte = 0x06; NAK byte = 0x15.
REQ-017 'L' received while o_stall=0 (running) -> RESP(NAK); no state change otherwise.
REQ-018 LOAD_CNT: next strobed byte N; 1 <= N <= MAX_INSTRUCTION -> LOAD_DATA with word counter = 0 and byte counter = 0; otherwise -> RESP(NAK) with no writes.
REQ-019 LOAD_DATA: bytes are assembled little-endian (first byte -> bits [7:0]); the 4th byte -> WRITE.
REQ-020 WRITE: lasts exactly one cycle; o_inst_we=1, o_inst_addr = word counter, o_inst_data = assembled word; word counter increments.
REQ-021 After WRITE: if word counter == N -> RESP(ACK); else -> LOAD_DATA.
REQ-022 A byte strobed during the WRITE cycle is captured as byte 0 of the next word; no byte is lost.
REQ-023 RESP: o_tx_valid=1 with o_tx_data stable until the handshake; then -> IDLE on the next cycle.
REQ-024 Bytes strobed while in RESP or STEP are dropped.
REQ-025 o_stall remains 1 for the whole of any load.
REQ-026 o_inst_we is 0 in every state except WRITE.
REQ-027 Latency: 'R'/'H' change o_stall on the edge after the strobe; o_tx_valid rises on that same edge.

Reset
REQ-028 While rst=0: state=IDLE, o_stall=1, o_inst_we=0, o_tx_valid=0, o_inst_addr=0, o_inst_data=0, o_tx_data=0, and all counters = 0.
REQ-029 Reset asserted mid-load aborts the load; partial words are discarded; already written words remain in memory.

Configuration
REQ-030 Macro DEBUG_STEP_EN: when defined, 0x53 'S' in IDLE with o_stall=1 -> STEP.
REQ-031 STEP drives o_stall=0 for exactly one cycle, then o_stall=1, then -> RESP(ACK).
REQ-032 'S' while o_stall=0 -> RESP(NAK).
REQ-033 Without DEBUG_STEP_EN: STEP state is absent and 'S' is an unknown command (NAK).

Verification
REQ-034 Reset, then sample -> o_stall=1, o_tx_valid=0, o_inst_we=0.
REQ-035 Bytes 4C 02 78 56 34 12 EF BE AD DE -> two we pulses: addr 0 data 0x12345678, addr 1 data 0xDEADBEEF, then tx 0x06.
REQ-036 Bytes 4C 00, and 4C 0B with MAX_INSTRUCTION=10 -> tx 0x15 each time, no we pulse.
REQ-037 Bytes 52 then 4C -> o_stall=0, tx 0x06, then tx 0x15; bytes 48 -> o_stall=1, tx 0x06.
REQ-038 With DEBUG_STEP_EN: byte 53 while halted -> o_stall low for exactly 1 cycle, tx 0x06; with i_tx_ready held 0 for 5 cycles -> o_tx_valid and o_tx_data stay stable throughout.
REQ-039 Reset pulsed after 4C 01 AA BB -> state IDLE, no we pulse; a fresh load then succeeds.
